// File: rtl/cond_branch_ctrl.sv
// -----------------------------------------------------------------------------
// cond_branch_ctrl
//
// Conditional branch resolution unit for the execute stage. Holds the
// architectural condition flags {N,Z,C,V} written by the ALU, evaluates a
// 4-bit condition code against them for each branch, and produces a
// registered taken decision, branch target and fetch/decode flush request.
//
// Configuration macro:
//   CBC_FLAG_FWD_EN - when defined, a branch presented in the same cycle as
//                     flag_we=1 evaluates against alu_flags (same-cycle
//                     forwarding). When undefined, branches always evaluate
//                     the registered flags.
//
// Parameters:
//   PC_WIDTH   - program counter / target width
//   OFF_WIDTH  - signed branch offset width (two's complement, <= PC_WIDTH)
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   asynchronous active-high reset
//   flag_we     in   ALU flag write enable
//   alu_flags   in   new flags {N,Z,C,V}
//   br_valid    in   branch instruction present this cycle
//   br_cond     in   condition code
//   br_pc       in   address of the branch instruction
//   br_offset   in   signed offset relative to br_pc
//   flags       out  current flag register
//   take_branch out  registered taken decision (one cycle per branch)
//   br_target   out  registered target, updated for every valid branch
//   flush       out  registered squash request (mirrors take_branch)
// -----------------------------------------------------------------------------
module cond_branch_ctrl #(
    parameter int PC_WIDTH  = 16,
    parameter int OFF_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flag_we,
    input  logic [3:0]           alu_flags,
    input  logic                 br_valid,
    input  logic [3:0]           br_cond,
    input  logic [PC_WIDTH-1:0]  br_pc,
    input  logic [OFF_WIDTH-1:0] br_offset,
    output logic [3:0]           flags,
    output logic                 take_branch,
    output logic [PC_WIDTH-1:0]  br_target,
    output logic                 flush
);

    // Condition decode: f = {N,Z,C,V}
    function automatic logic cond_decode(input logic [3:0] cond, input logic [3:0] f);
        logic n;
        logic z;
        logic c;
        logic v;
        logic res;
        n = f[3];
        z = f[2];
        c = f[1];
        v = f[0];
        case (cond)
            4'h0:    res = z;
            4'h1:    res = ~z;
            4'h2:    res = c;
            4'h3:    res = ~c;
            4'h4:    res = n;
            4'h5:    res = ~n;
            4'h6:    res = v;
            4'h7:    res = ~v;
            4'h8:    res = c & ~z;
            4'h9:    res = ~c | z;
            4'hA:    res = ~(n ^ v);
            4'hB:    res = n ^ v;
            4'hC:    res = ~z & ~(n ^ v);
            4'hD:    res = z | (n ^ v);
            4'hE:    res = 1'b1;
            4'hF:    res = 1'b0;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    logic [3:0]          flags_r;
    logic                take_r;
    logic                flush_r;
    logic [PC_WIDTH-1:0] target_r;

    logic [3:0]          eval_flags_s;
    logic                cond_true_s;
    logic [PC_WIDTH-1:0] offset_ext_s;
    logic [PC_WIDTH-1:0] next_target_s;

    // Select the flag set the current branch is evaluated against
    always_comb begin
        eval_flags_s = flags_r;
`ifdef CBC_FLAG_FWD_EN
        if (flag_we) begin
            eval_flags_s = alu_flags;
        end else begin
            eval_flags_s = flags_r;
        end
`endif
    end

    // Condition evaluation and target arithmetic (wraps modulo 2^PC_WIDTH)
    always_comb begin
        cond_true_s   = cond_decode(br_cond, eval_flags_s);
        offset_ext_s  = PC_WIDTH'(signed'(br_offset));
        next_target_s = br_pc + offset_ext_s;
    end

    // Flag register and registered branch decision/target
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_r  <= 4'b0000;
            take_r   <= 1'b0;
            flush_r  <= 1'b0;
            target_r <= {PC_WIDTH{1'b0}};
        end else begin
            if (flag_we) begin
                flags_r <= alu_flags;
            end
            take_r  <= br_valid & cond_true_s;
            flush_r <= br_valid & cond_true_s;
            // Target tracks every valid branch, taken or not
            if (br_valid) begin
                target_r <= next_target_s;
            end
        end
    end

    assign flags       = flags_r;
    assign take_branch = take_r;
    assign flush       = flush_r;
    assign br_target   = target_r;

endmodule

// File: tb/tb_cond_branch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cond_branch_ctrl
//
// Self-checking bench for cond_branch_ctrl: directed cases plus randomized
// traffic, compared against a behavioural model of flags, decision and target.
// -----------------------------------------------------------------------------
module tb_cond_branch_ctrl;

    localparam int PW = 16;
    localparam int OW = 8;
`ifdef CBC_FLAG_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          flag_we;
    logic [3:0]    alu_flags;
    logic          br_valid;
    logic [3:0]    br_cond;
    logic [PW-1:0] br_pc;
    logic [OW-1:0] br_offset;
    logic [3:0]    flags;
    logic          take_branch;
    logic [PW-1:0] br_target;
    logic          flush;

    int n_checks;
    int n_pass;

    // model state
    logic [3:0]    m_flags;
    logic          m_take;
    logic [PW-1:0] m_target;

    cond_branch_ctrl #(.PC_WIDTH(PW), .OFF_WIDTH(OW)) dut (
        .clk         (clk),
        .rst         (rst),
        .flag_we     (flag_we),
        .alu_flags   (alu_flags),
        .br_valid    (br_valid),
        .br_cond     (br_cond),
        .br_pc       (br_pc),
        .br_offset   (br_offset),
        .flags       (flags),
        .take_branch (take_branch),
        .br_target   (br_target),
        .flush       (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Conditions come in complementary pairs: odd code = inverse of even code.
    function automatic bit ref_cond(input int cond, input logic [3:0] f);
        bit n, z, c, v, base;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (cond / 2)
            0: base = z;
            1: base = c;
            2: base = n;
            3: base = v;
            4: base = c && !z;
            5: base = (n == v);
            6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return (cond % 2 == 1) ? !base : base;
    endfunction

    // Apply one cycle of stimulus, advance model, check all outputs after edge
    task automatic drive(input logic fwe, input logic [3:0] af, input logic bv,
                         input logic [3:0] bc, input logic [PW-1:0] pc,
                         input logic [OW-1:0] off);
        logic [3:0] ev;
        int sum;
        flag_we   = fwe;
        alu_flags = af;
        br_valid  = bv;
        br_cond   = bc;
        br_pc     = pc;
        br_offset = off;
        ev = (FWD && fwe) ? af : m_flags;
        m_take = bv && ref_cond(int'(bc), ev);
        if (bv) begin
            sum = int'(pc) + int'($signed(off));
            m_target = PW'(sum & 32'h0000FFFF);
        end
        if (fwe) m_flags = af;
        @(posedge clk);
        #1;
        check("flags", 32'(flags), 32'(m_flags));
        check("take_branch", 32'(take_branch), 32'(m_take));
        check("flush", 32'(flush), 32'(m_take));
        check("br_target", 32'(br_target), 32'(m_target));
    endtask

    task automatic idle();
        drive(1'b0, 4'h0, 1'b0, 4'h0, 16'h0000, 8'h00);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b1;
        flag_we = 1'b0; alu_flags = 4'h0; br_valid = 1'b0;
        br_cond = 4'h0; br_pc = 16'h0000; br_offset = 8'h00;
        m_flags = 4'h0; m_take = 1'b0; m_target = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        check("rst_flags", 32'(flags), 32'h0);
        check("rst_take", 32'(take_branch), 32'h0);
        check("rst_flush", 32'(flush), 32'h0);
        check("rst_target", 32'(br_target), 32'h0);
        rst = 1'b0;

        // Reset mid-operation with take_branch=1, flags=F
        drive(1'b1, 4'hF, 1'b0, 4'h0, 16'h0000, 8'h00);
        drive(1'b0, 4'h0, 1'b1, 4'hE, 16'h1234, 8'h05);
        check("pre_rst_take", 32'(take_branch), 32'h1);
        check("pre_rst_flags", 32'(flags), 32'hF);
        br_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("async_rst_flags", 32'(flags), 32'h0);
        check("async_rst_take", 32'(take_branch), 32'h0);
        check("async_rst_flush", 32'(flush), 32'h0);
        check("async_rst_target", 32'(br_target), 32'h0);
        #1;
        rst = 1'b0;
        m_flags = 4'h0; m_take = 1'b0; m_target = 16'h0000;
        drive(1'b0, 4'h0, 1'b1, 4'h0, 16'h0020, 8'h01);
        check("post_rst_eq", 32'(take_branch), 32'h0);

        // All flags x all conditions
        for (int f = 0; f < 16; f++) begin
            for (int c = 0; c < 16; c++) begin
                drive(1'b1, 4'(f), 1'b0, 4'h0, 16'h0000, 8'h00);
                drive(1'b0, 4'h0, 1'b1, 4'(c), 16'(f * 16 + c), 8'(c));
            end
        end

        // Spot checks against fixed expectations
        drive(1'b1, 4'b0100, 1'b0, 4'h0, 16'h0000, 8'h00);
        drive(1'b0, 4'h0, 1'b1, 4'h0, 16'h0000, 8'h00);
        check("spot_eq", 32'(take_branch), 32'h1);
        drive(1'b1, 4'b1000, 1'b0, 4'h0, 16'h0000, 8'h00);
        drive(1'b0, 4'h0, 1'b1, 4'hA, 16'h0000, 8'h00);
        check("spot_ge", 32'(take_branch), 32'h0);
        drive(1'b1, 4'b1001, 1'b0, 4'h0, 16'h0000, 8'h00);
        drive(1'b0, 4'h0, 1'b1, 4'hC, 16'h0000, 8'h00);
        check("spot_gt", 32'(take_branch), 32'h1);

        // Target arithmetic
        drive(1'b0, 4'h0, 1'b1, 4'hE, 16'h0010, 8'hFE);
        check("tgt_neg", 32'(br_target), 32'h000E);
        drive(1'b0, 4'h0, 1'b1, 4'hE, 16'hFFFF, 8'h02);
        check("tgt_wrap", 32'(br_target), 32'h0001);
        drive(1'b0, 4'h0, 1'b1, 4'hE, 16'h0000, 8'h80);
        check("tgt_min", 32'(br_target), 32'hFF80);

        // Not-valid AL holds target; NV valid updates target
        drive(1'b0, 4'h0, 1'b0, 4'hE, 16'h4000, 8'h10);
        check("nv_al_take", 32'(take_branch), 32'h0);
        check("nv_al_hold", 32'(br_target), 32'hFF80);
        drive(1'b0, 4'h0, 1'b1, 4'hF, 16'h4000, 8'h10);
        check("nv_take", 32'(take_branch), 32'h0);
        check("nv_flush", 32'(flush), 32'h0);
        check("nv_target", 32'(br_target), 32'h4010);

        // Same-cycle flag write and branch
        drive(1'b1, 4'h0, 1'b0, 4'h0, 16'h0000, 8'h00);
        drive(1'b1, 4'b0100, 1'b1, 4'h0, 16'h0100, 8'h04);
        check("fwd_take", 32'(take_branch), FWD ? 32'h1 : 32'h0);
        check("fwd_flags", 32'(flags), 32'h4);

        // Back-to-back AL, NV, AL
        drive(1'b0, 4'h0, 1'b1, 4'hE, 16'h0200, 8'h01);
        check("b2b_0", 32'({take_branch, flush}), 32'h3);
        drive(1'b0, 4'h0, 1'b1, 4'hF, 16'h0300, 8'h01);
        check("b2b_1", 32'({take_branch, flush}), 32'h0);
        drive(1'b0, 4'h0, 1'b1, 4'hE, 16'h0400, 8'h01);
        check("b2b_2", 32'({take_branch, flush}), 32'h3);
        idle();
        check("b2b_end", 32'(take_branch), 32'h0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 1)),
                  4'($urandom), 16'($urandom), 8'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cond_branch_ctrl.md
# cond_branch_ctrl

Conditional branch resolution unit for the CPU execute stage. It holds the architectural condition flags (N, Z, C, V) written by the ALU. It evaluates a 4-bit condition code against those flags for each branch instruction. It outputs a registered taken decision, the computed branch target and a pipeline flush request to fetch/decode.

## Interface
Parameters:
- PC_WIDTH, 16, program counter and target width
- OFF_WIDTH, 8, signed branch offset width (two's complement, ≤ PC_WIDTH)

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- flag_we  input  1  ALU flag write enable
- alu_flags  input  4  new flags {N,Z,C,V} (bit 3 = N, bit 0 = V)
- br_valid  input  1  branch instruction present this cycle
- br_cond  input  4  condition code
- br_pc  input  PC_WIDTH  address of the branch instruction
- br_offset  input  OFF_WIDTH  signed offset
- flags  output  4  current flag register {N,Z,C,V}
- take_branch  output  1  registered: branch taken
- br_target  output  PC_WIDTH  registered target address
- flush  output  1  registered: squash younger instructions (equals take_branch)

One clock; reset is asynchronous and active-high.

## Operation
- Flag register: on flag_we=1, flags <= alu_flags; otherwise it holds.
- Evaluation flags: with the configuration macro defined, the unit uses alu_flags when flag_we=1 in the same cycle. Otherwise it uses the registered flags.
- Condition decode:
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C
  - 4 MI N; 5 PL !N; 6 VS V; 7 VC !V
  - 8 HI C&!Z; 9 LS !C|Z
  - A GE N==V; B LT N!=V
  - C GT !Z&(N==V); D LE Z|(N!=V)
  - E AL always 1; F NV always 0
- cond_true = decode(br_cond, eval flags).
- take_branch <= br_valid & cond_true.
- flush <= br_valid & cond_true.
- br_target <= br_pc + sign_extend(br_offset), computed modulo 2^PC_WIDTH (wraps silently).
- br_target is updated whenever br_valid=1, taken or not. It holds otherwise.
- br_valid=0: take_branch and flush are 0 the next cycle regardless of br_cond.
- Offsets are relative to the branch's own address. No +1 adjustment.

## Timing
- Reset values:
  - flags = 4'b0000
  - take_branch = 0
  - flush = 0
  - br_target = 0
- Reset asserted mid-operation clears all of these immediately (asynchronously). A pending decision is discarded.
- Decision latency: 1 cycle. A branch presented in cycle n drives take_branch/flush/br_target in cycle n+1 for exactly one cycle per valid branch.
- Back-to-back branches are accepted every cycle. There is no stall or handshake.
- Flag write and branch evaluation in the same cycle: the flag register updates at that edge either way. The branch sees old or new flags per the configuration macro.
- flags output is the register value. It changes one cycle after flag_we.

## Configuration
- CBC_FLAG_FWD_EN defined: same-cycle forwarding enabled. A branch in the same cycle as flag_we=1 evaluates against alu_flags.
- Not defined: the branch always evaluates registered flags. The compiler/pipeline must insert one cycle between a flag-setting op and a dependent branch.

## Test plan
- Reset:
  - Stimulus: assert rst while take_branch=1 and flags=4'hF.
  - Required: flags=0, take_branch=0, flush=0, br_target=0 immediately.
  - Then: after release, br_cond=EQ with br_valid=1 gives take_branch=0 (Z=0).
- All conditions:
  - Stimulus: for each flags value 0..F and each br_cond 0..F, set flag_we then branch next cycle.
  - Required: take_branch matches the decode table.
  - Spot checks: flags=4'b0100 with cond EQ gives 1. flags=4'b1000 with cond GE gives 0. flags=4'b1001 with cond GT gives 1.
- Target arithmetic:
  - br_pc=16'h0010, offset=8'hFE gives br_target=16'h000E.
  - br_pc=16'hFFFF, offset=8'h02 gives br_target=16'h0001 (wrap).
  - br_pc=16'h0000, offset=8'h80 gives br_target=16'hFF80.
- Not-valid and NV:
  - br_valid=0 with cond AL gives take_branch=0, and br_target holds its previous value.
  - br_valid=1 with cond NV gives take_branch=0, flush=0, and br_target is updated.
- Forwarding:
  - Stimulus: flags=0; same cycle flag_we=1, alu_flags=4'b0100, br_valid=1, br_cond=EQ.
  - Required: take_branch=1 with CBC_FLAG_FWD_EN defined, 0 without.
  - In both cases flags=4'b0100 after the edge.
- Back-to-back:
  - Three consecutive branches (AL, NV, AL) give take_branch sequence 1,0,1 and flush identical.
